// File: rtl/fa_chk_pkg.sv
// Shared types for the full-adder response checker: FSM states, the delay-line
// entry and the golden adder.
package fa_chk_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} chk_state_t;

  typedef struct packed {
    logic       v;
    logic       a;
    logic       b;
    logic       cin;
    logic [1:0] exp;
  } fa_vec_t;

  localparam int MAX_LATENCY = 8;

  function automatic logic [1:0] fa_golden(input logic a, input logic b, input logic cin);
    return {1'b0, a} + {1'b0, b} + {1'b0, cin};
  endfunction

endpackage

// File: rtl/fa_delay_line.sv
// Fixed-depth delay line that lines the golden entry up with the DUT output.
// DEPTH=0 passes straight through; flush empties every stage.
module fa_delay_line
  import fa_chk_pkg::*;
#(
  parameter int  DEPTH = 1,
  parameter type T     = fa_vec_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  T     din,
  output T     dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ok;
      assign unused_ok = ^{clk, rst_n, flush};
      assign dout      = din;
    end else begin : g_sr
      T sr [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else if (flush) begin
          // Whole-entry clear also drops the valid bits of anything in flight.
          for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
          sr[0] <= din;
          for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
      end

      assign dout = sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/chk_full_adder_2.sv
// Clocked response checker for the 1-bit full adder: golden model, latency
// alignment, compare, counters and first-error capture.
module chk_full_adder_2
  import fa_chk_pkg::*;
#(
  parameter int NUM_VECTORS = 16,
  parameter int DUT_LATENCY = 0,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             A,
  input  logic             B,
  input  logic             Cin,
  input  logic             Sum,
  input  logic             Cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_flag,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [4:0]       first_err_vec
);

  localparam logic [CNT_W-1:0] NUM_V = CNT_W'(NUM_VECTORS);

  chk_state_t state, state_nxt;
  fa_vec_t    issue, aligned;
  logic       flush, cmp_fire, mismatch, last_cmp;

  assign flush = start && (state != RUN);

  always_comb begin
    issue     = '0;
    issue.v   = in_valid && (state == RUN);
    issue.a   = A;
    issue.b   = B;
    issue.cin = Cin;
    issue.exp = fa_golden(A, B, Cin);
  end

  fa_delay_line #(.DEPTH(DUT_LATENCY), .T(fa_vec_t)) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .din   (issue),
    .dout  (aligned)
  );

  // Case inequality so X/Z on the DUT outputs is reported as a mismatch.
  assign cmp_fire = aligned.v && (state == RUN);
  assign mismatch = ({Cout, Sum} !== aligned.exp);
  assign last_cmp = cmp_fire && (vec_cnt == NUM_V - 1'b1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start)    state_nxt = RUN;
      RUN:        if (last_cmp) state_nxt = DONE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_cnt       <= '0;
      err_cnt       <= '0;
      err_flag      <= 1'b0;
      first_err_idx <= '0;
      first_err_vec <= '0;
    end else if (flush) begin
      vec_cnt       <= '0;
      err_cnt       <= '0;
      err_flag      <= 1'b0;
      first_err_idx <= '0;
      first_err_vec <= '0;
    end else if (cmp_fire) begin
      vec_cnt <= vec_cnt + 1'b1;
      if (mismatch) begin
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        if (!err_flag) begin
          err_flag      <= 1'b1;
          first_err_idx <= vec_cnt;
          first_err_vec <= {aligned.a, aligned.b, aligned.cin, Sum, Cout};
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == '0);

endmodule

// File: tb/tb_chk_full_adder_2.sv
// Bench for chk_full_adder_2: three checker configurations driven by a fake
// full-adder DUT with selectable delay and fault, checked against an issue-log model.
module tb_chk_full_adder_2;

  localparam int NI = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [NI-1:0] start = '0, in_valid = '0, a = '0, b = '0, cin = '0, sum = '0, cout = '0;
  logic [NI-1:0] busy, done, pass, err_flag;
  logic [1:0][7:0] vc, ec, fi;
  logic [1:0][4:0] fv;
  logic [1:0] vc_s, ec_s, fi_s;
  logic [4:0] fv_s;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  chk_full_adder_2 #(.NUM_VECTORS(8), .DUT_LATENCY(0), .CNT_W(8)) u_l0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .in_valid(in_valid[0]), .A(a[0]), .B(b[0]),
    .Cin(cin[0]), .Sum(sum[0]), .Cout(cout[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_flag(err_flag[0]), .vec_cnt(vc[0]), .err_cnt(ec[0]), .first_err_idx(fi[0]),
    .first_err_vec(fv[0]));

  chk_full_adder_2 #(.NUM_VECTORS(16), .DUT_LATENCY(3), .CNT_W(8)) u_l3 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .in_valid(in_valid[1]), .A(a[1]), .B(b[1]),
    .Cin(cin[1]), .Sum(sum[1]), .Cout(cout[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_flag(err_flag[1]), .vec_cnt(vc[1]), .err_cnt(ec[1]), .first_err_idx(fi[1]),
    .first_err_vec(fv[1]));

  chk_full_adder_2 #(.NUM_VECTORS(3), .DUT_LATENCY(0), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .in_valid(in_valid[2]), .A(a[2]), .B(b[2]),
    .Cin(cin[2]), .Sum(sum[2]), .Cout(cout[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .err_flag(err_flag[2]), .vec_cnt(vc_s), .err_cnt(ec_s), .first_err_idx(fi_s),
    .first_err_vec(fv_s));

  function automatic int lat_of(int k);  return (k == 1) ? 3 : 0; endfunction
  function automatic int nv_of(int k);   return (k == 0) ? 8 : (k == 1) ? 16 : 3; endfunction
  function automatic int emax_of(int k); return (k == 2) ? 3 : 255; endfunction
  function automatic int get_vc(int k); return (k == 2) ? int'(vc_s) : int'(vc[k]); endfunction
  function automatic int get_ec(int k); return (k == 2) ? int'(ec_s) : int'(ec[k]); endfunction
  function automatic int get_fi(int k); return (k == 2) ? int'(fi_s) : int'(fi[k]); endfunction
  function automatic int get_fv(int k); return (k == 2) ? int'(fv_s) : int'(fv[k]); endfunction

  function automatic logic [1:0] fa(input logic [2:0] v);
    return 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a log of issued vectors keyed by edge number; the compare
  // at edge n looks up whatever was issued at edge n-latency in the current run.
  int         m_st [NI];  // 0 idle, 1 run, 2 done
  int         m_vc [NI], m_ec [NI], m_fi [NI], m_fv [NI];
  bit         m_ef [NI];
  int         run_t [NI];
  int         iss_t [NI][64];
  logic [2:0] iss_vec [NI][64];
  int         edge_n = 0;

  task automatic model_clear(int k);
    m_vc[k] = 0; m_ec[k] = 0; m_fi[k] = 0; m_fv[k] = 0; m_ef[k] = 1'b0;
  endtask

  task automatic model_step();
    edge_n++;
    for (int k = 0; k < NI; k++) begin
      if (m_st[k] != 1) begin
        if (start[k]) begin
          m_st[k] = 1;
          model_clear(k);
          run_t[k] = edge_n;
        end
      end else begin
        int t;
        logic [2:0] v;
        if (in_valid[k]) begin
          iss_t[k][edge_n % 64]   = edge_n;
          iss_vec[k][edge_n % 64] = {a[k], b[k], cin[k]};
        end
        t = edge_n - lat_of(k);
        if (t > run_t[k] && iss_t[k][t % 64] == t) begin
          v = iss_vec[k][t % 64];
          if ({cout[k], sum[k]} !== fa(v)) begin
            if (m_ec[k] < emax_of(k)) m_ec[k]++;
            if (!m_ef[k]) begin
              m_ef[k] = 1'b1;
              m_fi[k] = m_vc[k];
              m_fv[k] = int'({v, sum[k], cout[k]});
            end
          end
          m_vc[k]++;
          if (m_vc[k] == nv_of(k)) m_st[k] = 2;
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      m_st[k] = 0; model_clear(k); run_t[k] = 0;
      for (int s = 0; s < 64; s++) iss_t[k][s] = -1;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < NI; k++) begin m_st[k] = 0; model_clear(k); end
      end else begin
        model_step();
      end
    end
  end

  // Compare process: every output of every instance, every cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        chk($sformatf("k%0d busy", k),          int'(busy[k]),     int'(m_st[k] == 1));
        chk($sformatf("k%0d done", k),          int'(done[k]),     int'(m_st[k] == 2));
        chk($sformatf("k%0d pass", k),          int'(pass[k]),     int'(m_st[k] == 2 && m_ec[k] == 0));
        chk($sformatf("k%0d err_flag", k),      int'(err_flag[k]), int'(m_ef[k]));
        chk($sformatf("k%0d vec_cnt", k),       get_vc(k),         m_vc[k]);
        chk($sformatf("k%0d err_cnt", k),       get_ec(k),         m_ec[k]);
        chk($sformatf("k%0d first_err_idx", k), get_fi(k),         m_fi[k]);
        chk($sformatf("k%0d first_err_vec", k), get_fv(k),         m_fv[k]);
      end
    end
  end

  // Fake DUT: correct adder, optionally delayed (dly) and faulted (mode 1: Sum
  // stuck at 0, mode 2: both outputs inverted).
  int         dly  [NI] = '{default: 0};
  int         mode [NI] = '{default: 0};
  logic [1:0] hist [NI][16];
  int         hp = 0;

  task automatic cyc();
    for (int k = 0; k < NI; k++) begin
      logic [1:0] r;
      hist[k][hp % 16] = fa({a[k], b[k], cin[k]});
      r = hist[k][(hp + 16 - dly[k]) % 16];
      if (mode[k] == 1)      r[0] = 1'b0;
      else if (mode[k] == 2) r = ~r;
      {cout[k], sum[k]} = r;
    end
    hp++;
    @(negedge clk);
  endtask

  task automatic drive(input int k, input bit v, input logic [2:0] vec);
    in_valid[k] = v;
    {a[k], b[k], cin[k]} = vec;
    cyc();
  endtask

  task automatic pulse_start(input int k);
    start[k] = 1'b1; in_valid[k] = 1'b0;
    cyc();
    start[k] = 1'b0;
  endtask

  task automatic run_to_done(input int k, input bit seq, input int budget);
    int i;
    i = 0;
    while (!done[k] && i < budget) begin
      drive(k, 1'b1, seq ? 3'(i) : 3'($urandom_range(0, 7)));
      i++;
    end
    in_valid[k] = 1'b0;
    chk($sformatf("k%0d done within budget", k), int'(done[k]), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < NI; k++)
      for (int s = 0; s < 16; s++) hist[k][s] = '0;
    cyc(); cyc();
    chk("reset busy", int'(busy[0]), 0);
    chk("reset vec_cnt", get_vc(1), 0);
    rst_n = 1'b1;
    cyc();

    // Exhaustive pass at latency 0.
    pulse_start(0);
    run_to_done(0, 1'b1, 20);
    chk("exh pass", int'(pass[0]), 1);
    chk("exh vec_cnt", get_vc(0), 8);
    chk("exh err_cnt", get_ec(0), 0);
    repeat (3) drive(0, 1'b1, 3'($urandom_range(0, 7)));
    in_valid[0] = 1'b0;
    chk("done holds vec_cnt", get_vc(0), 8);

    // Sum stuck at 0, restarted from DONE.
    mode[0] = 1;
    pulse_start(0);
    chk("restart clears vec_cnt", get_vc(0), 0);
    run_to_done(0, 1'b1, 20);
    chk("stuck err_cnt", get_ec(0), 4);
    chk("stuck first_err_idx", get_fi(0), 1);
    chk("stuck first_err_vec", get_fv(0), 5'b00100);
    chk("stuck pass", int'(pass[0]), 0);

    // Latency 3, DUT aligned, continuous random issue.
    dly[1] = 3;
    pulse_start(1);
    run_to_done(1, 1'b0, 60);
    chk("lat3 pass", int'(pass[1]), 1);
    chk("lat3 vec_cnt", get_vc(1), 16);

    // Latency 3 checker against a 2-cycle DUT.
    dly[1] = 2;
    pulse_start(1);
    run_to_done(1, 1'b1, 60);
    chk("lat2 err_cnt nonzero", int'(get_ec(1) != 0), 1);
    chk("lat2 pass", int'(pass[1]), 0);

    // Gaps and ignored start mid-run.
    dly[1] = 3;
    pulse_start(1);
    for (int j = 0; j < 6; j++) begin
      drive(1, 1'b1, 3'($urandom_range(0, 7)));
      drive(1, 1'b0, 3'($urandom_range(0, 7)));
    end
    repeat (3) drive(1, 1'b0, 3'($urandom_range(0, 7)));
    chk("gaps vec_cnt", get_vc(1), 6);
    pulse_start(1);
    chk("mid-run start keeps vec_cnt", get_vc(1), 6);
    chk("mid-run start keeps busy", int'(busy[1]), 1);
    run_to_done(1, 1'b0, 60);
    chk("gaps pass", int'(pass[1]), 1);

    // in_valid while idle is dropped.
    repeat (4) drive(2, 1'b1, 3'($urandom_range(0, 7)));
    in_valid[2] = 1'b0;
    chk("idle in_valid vec_cnt", get_vc(2), 0);

    // Saturating error counter, always-wrong DUT.
    mode[2] = 2;
    pulse_start(2);
    run_to_done(2, 1'b0, 20);
    chk("sat err_cnt", get_ec(2), 3);
    chk("sat pass", int'(pass[2]), 0);
    mode[2] = 0;
    pulse_start(2);
    run_to_done(2, 1'b0, 20);
    chk("sat restart pass", int'(pass[2]), 1);

    // Reset in the middle of a run.
    pulse_start(1);
    repeat (5) drive(1, 1'b1, 3'($urandom_range(0, 7)));
    in_valid[1] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midreset busy", int'(busy[1]), 0);
    chk("midreset vec_cnt", get_vc(1), 0);
    chk("midreset done", int'(done[0]), 0);
    chk("midreset err_cnt", get_ec(0), 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    pulse_start(1);
    run_to_done(1, 1'b0, 60);
    chk("post-reset pass", int'(pass[1]), 1);

    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
